// File: rtl/gray_to_binary.sv
// gray_to_binary: registered reflected-Gray to binary converter with valid strobe
//   clk       rising-edge clock
//   rst       asynchronous active-high reset, clears binary and out_valid
//   in_valid  capture gray on this edge
//   gray      Gray-coded input word
//   out_valid one-cycle pulse marking a fresh result on binary
//   binary    converted word, one cycle after capture, held between results
module gray_to_binary #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] gray,
  output logic             out_valid,
  output logic [WIDTH-1:0] binary
);
  logic [WIDTH-1:0] conv;
  logic [WIDTH-1:0] binary_d, binary_q;
  logic             valid_d, valid_q;
  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < WIDTH; i++) begin : g_conv
    assign conv[i] = ^gray[WIDTH-1:i];
  end
  always_comb begin
    binary_d = in_valid ? conv : binary_q;
    valid_d  = in_valid;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      binary_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      binary_q <= binary_d;
      valid_q  <= valid_d;
    end
  end
  assign binary    = binary_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_gray_to_binary.sv
// tb_gray_to_binary: self-checking bench for gray_to_binary at WIDTH 4, 1 and 8
module tb_gray_to_binary;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] gray4 = '0;
  logic [0:0] gray1 = '0;
  logic [7:0] gray8 = '0;
  logic       ov4, ov1, ov8;
  logic [3:0] bin4;
  logic [0:0] bin1;
  logic [7:0] bin8;
  int checks = 0;
  int errors = 0;
  int e4 = 0, e1 = 0, e8 = 0;
  logic ev = 1'b0;
  typedef struct {logic [3:0] g; logic [3:0] b;} vec_t;
  vec_t vec[7];
  always #5 clk = ~clk;
  gray_to_binary #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .in_valid(in_valid), .gray(gray4), .out_valid(ov4), .binary(bin4));
  gray_to_binary #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .in_valid(in_valid), .gray(gray1), .out_valid(ov1), .binary(bin1));
  gray_to_binary #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .in_valid(in_valid), .gray(gray8), .out_valid(ov8), .binary(bin8));
  // Reference: the binary value whose Gray encoding b^(b>>1) equals g.
  function automatic int inv(input int w, input int g);
    for (int b = 0; b < (1 << w); b++)
      if ((b ^ (b >> 1)) == g) return b;
    return -1;
  endfunction
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic v, input logic [7:0] g);
    logic [7:0] d;
    @(negedge clk);
    d = v ? g : 8'($urandom);
    in_valid = v;
    gray4 = d[3:0];
    gray1 = d[0:0];
    gray8 = d;
    @(posedge clk);
    #1;
    if (v) begin
      e4 = inv(4, int'(d[3:0]));
      e1 = inv(1, int'(d[0]));
      e8 = inv(8, int'(d));
    end
    ev = v;
  endtask
  task automatic check_all(input string tag);
    chk({tag, "_v4"}, int'(ov4), int'(ev));
    chk({tag, "_b4"}, int'(bin4), e4);
    chk({tag, "_v1"}, int'(ov1), int'(ev));
    chk({tag, "_b1"}, int'(bin1), e1);
    chk({tag, "_v8"}, int'(ov8), int'(ev));
    chk({tag, "_b8"}, int'(bin8), e8);
  endtask
  task automatic model_reset();
    e4 = 0;
    e1 = 0;
    e8 = 0;
    ev = 1'b0;
  endtask
  initial begin
    int prev;
    vec[0] = '{4'b0000, 4'b0000};
    vec[1] = '{4'b0001, 4'b0001};
    vec[2] = '{4'b0011, 4'b0010};
    vec[3] = '{4'b0010, 4'b0011};
    vec[4] = '{4'b0110, 4'b0100};
    vec[5] = '{4'b1000, 4'b1111};
    vec[6] = '{4'b1111, 4'b1010};
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("por");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, {4'b0000, vec[i].g});
      chk($sformatf("vec%0d_b", i), int'(bin4), int'(vec[i].b));
      chk($sformatf("vec%0d_v", i), int'(ov4), 1);
    end
    @(negedge clk);
    in_valid = 1'b1;
    gray4 = 4'b0101;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    @(posedge clk);
    #1;
    check_all("arst_hold");
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i));
      check_all($sformatf("sweep4_%0d", i));
    end
    step(1'b1, 8'b0000_0110);
    check_all("gap0");
    chk("gap0_b", int'(bin4), 4);
    step(1'b0, 8'h00);
    check_all("gap1");
    chk("gap1_b", int'(bin4), 4);
    step(1'b0, 8'h00);
    check_all("gap2");
    step(1'b1, 8'b0000_1000);
    check_all("gap3");
    chk("gap3_b", int'(bin4), 15);
    step(1'b1, 8'b0000_1111);
    check_all("mid0");
    @(negedge clk);
    in_valid = 1'b1;
    gray4 = 4'b0001;
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    step(1'b0, 8'h00);
    check_all("mid_rel0");
    step(1'b0, 8'h00);
    check_all("mid_rel1");
    prev = -1;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 8'(k ^ (k >> 1)));
      chk($sformatf("walk%0d", k), int'(bin4), k);
      if (prev >= 0) chk($sformatf("walk_inc%0d", k), (int'(bin4) - prev) & 15, 1);
      prev = int'(bin4);
    end
    prev = -1;
    for (int k = 0; k < 256; k++) begin
      step(1'b1, 8'(k ^ (k >> 1)));
      check_all($sformatf("walk8_%0d", k));
      if (prev >= 0) chk($sformatf("walk8_inc%0d", k), (int'(bin8) - prev) & 255, 1);
      prev = int'(bin8);
    end
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom));
      check_all($sformatf("rnd%0d", k));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
